// File: rtl/vic_prio.sv
// Vectored interrupt controller with N prioritised channels, where channel 0 has the highest priority.
// Each channel can be edge-latched or level-following, and the controller handles vector acknowledge on the CPU bus.
module vic_prio #(
    parameter int          N        = 2,
    parameter logic [N-1:0] EDGE    = {N{1'b1}},
    parameter logic [15:0] SPUR_VEC = 16'o000000
) (
    input  logic            clk_sys,
    input  logic            reset,
    input  logic            ce,
    input  logic [N-1:0]    ireq,
    input  logic [16*N-1:0] ivec,
    input  logic [N-1:0]    imask,
    input  logic            stb_i,
    output logic            irq_o,
    output logic [15:0]     dat_o,
    output logic            ack_o,
    output logic [N-1:0]    iack,
    output logic [N-1:0]    pend
);

    localparam int WW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

    state_t        state_reg, state_next;
    logic [N-1:0]  hist_reg, pend_reg, pend_next;
    logic [N-1:0]  eligible, clr;
    logic [N-1:0]  iack_reg, iack_next;
    logic          irq_reg, irq_next, ack_reg, ack_next;
    logic [15:0]   dat_reg, dat_next;
    logic [WW-1:0] win;
    logic          win_valid;

    assign eligible = pend_reg & ~imask;

    // Lowest index wins: scan downwards so the last hit is the smallest index.
    always_comb begin
        win       = '0;
        win_valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win       = WW'(i);
                win_valid = 1'b1;
            end
        end
    end

    // For an edge channel, a new rising edge outranks a service clear in the same cycle.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_pend
            assign pend_next[gi] = EDGE[gi]
                ? ((ireq[gi] & ~hist_reg[gi]) | (pend_reg[gi] & ~clr[gi]))
                : ireq[gi];
        end
    endgenerate

    // History follows ireq even in reset, so lines already high at release do not fire.
    always_ff @(posedge clk_sys) begin
        hist_reg <= ireq;
        if (reset) pend_reg <= '0;
        else       pend_reg <= pend_next;
    end

    always_ff @(posedge clk_sys) begin
        if (reset)   state_reg <= IDLE;
        else if (ce) state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (stb_i)  state_next = ACK;
            ACK:     if (!stb_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        irq_next  = irq_reg;
        ack_next  = ack_reg;
        dat_next  = dat_reg;
        iack_next = '0;
        clr       = '0;
        if (ce) begin
            case (state_reg)
                IDLE: begin
                    if (stb_i) begin
                        irq_next = 1'b0;
                        ack_next = 1'b1;
                        if (win_valid) begin
                            dat_next       = ivec[16*int'(win) +: 16];
                            iack_next[win] = 1'b1;
                            clr[win]       = 1'b1;
                        end else begin
                            dat_next = SPUR_VEC;
                        end
                    end else begin
                        irq_next = |eligible;
                    end
                end
                ACK: begin
                    irq_next = 1'b0;
                    if (!stb_i) begin
                        ack_next = 1'b0;
                        dat_next = 16'h0000;
                    end
                end
                default: irq_next = 1'b0;
            endcase
        end
    end

    // iack is not ce-gated: it falls on the very next clk_sys edge.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            irq_reg  <= 1'b0;
            ack_reg  <= 1'b0;
            dat_reg  <= 16'h0000;
            iack_reg <= '0;
        end else begin
            irq_reg  <= irq_next;
            ack_reg  <= ack_next;
            dat_reg  <= dat_next;
            iack_reg <= iack_next;
        end
    end

    assign irq_o = irq_reg;
    assign ack_o = ack_reg;
    assign dat_o = dat_reg;
    assign iack  = iack_reg;
    assign pend  = pend_reg;

endmodule

// File: tb/tb_vic_prio.sv
// Bench for vic_prio (N=4, channel 3 level-mode): directed scenarios followed by random traffic.
// Every clk_sys edge is checked against a behavioural reference model.
module tb_vic_prio;

    localparam int          NCH   = 4;
    localparam logic [3:0]  EDGEP = 4'b0111;
    localparam logic [15:0] SPUR  = 16'o000777;

    logic        clk_sys = 1'b0;
    logic        reset, ce, stb_i, irq_o, ack_o;
    logic [3:0]  ireq, imask, iack, pend;
    logic [63:0] ivec;
    logic [15:0] dat_o;

    logic [15:0] vecs [NCH];
    logic [3:0]  m_pend, m_prev, m_iack;
    logic        m_irq, m_ack, m_busy;
    logic [15:0] m_dat;

    int tests = 0;
    int fails = 0;
    int phase = 0;
    bit rand_ce = 1'b0;
    bit last_ce = 1'b0;

    vic_prio #(.N(NCH), .EDGE(EDGEP), .SPUR_VEC(SPUR)) dut (
        .clk_sys(clk_sys), .reset(reset), .ce(ce), .ireq(ireq), .ivec(ivec),
        .imask(imask), .stb_i(stb_i), .irq_o(irq_o), .dat_o(dat_o),
        .ack_o(ack_o), .iack(iack), .pend(pend)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < NCH; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Reference model built directly from the controller's behavioural rules.
    task automatic model_step();
        logic [3:0] elig, clr;
        int w;
        if (reset) begin
            m_pend = '0; m_irq = 0; m_ack = 0; m_dat = '0; m_iack = '0; m_busy = 0;
        end else begin
            elig   = m_pend & ~imask;
            clr    = '0;
            m_iack = '0;
            if (ce) begin
                if (!m_busy) begin
                    if (stb_i) begin
                        m_busy = 1; m_ack = 1; m_irq = 0;
                        w = lowest(elig);
                        if (w >= 0) begin
                            m_dat = vecs[w];
                            m_iack[w] = 1'b1;
                            clr[w] = 1'b1;
                        end else begin
                            m_dat = SPUR;
                        end
                    end else begin
                        m_irq = (elig != 0);
                    end
                end else begin
                    m_irq = 0;
                    if (!stb_i) begin m_busy = 0; m_ack = 0; m_dat = '0; end
                end
            end
            for (int k = 0; k < NCH; k++) begin
                if (EDGEP[k]) m_pend[k] = (ireq[k] & ~m_prev[k]) | (m_pend[k] & ~clr[k]);
                else          m_pend[k] = ireq[k];
            end
        end
        m_prev = ireq;
    endtask

    task automatic tick();
        if (!rand_ce) begin
            ce = (phase == 0);
            phase = (phase + 1) % 3;
        end
        @(posedge clk_sys);
        model_step();
        last_ce = ce;
        #1;
        chk("pend", {12'b0, pend}, {12'b0, m_pend});
        chk("iack", {12'b0, iack}, {12'b0, m_iack});
        chk("irq_o", {15'b0, irq_o}, {15'b0, m_irq});
        chk("ack_o", {15'b0, ack_o}, {15'b0, m_ack});
        chk("dat_o", dat_o, m_dat);
    endtask

    task automatic run_to_ce();
        for (int i = 0; i < 20; i++) begin
            tick();
            if (last_ce) return;
        end
        tests++;
        fails++;
        $error("FAIL ce_timeout: observed no ce edge expected one within 20 cycles");
    endtask

    task automatic do_ack(input string tag, input logic [15:0] exp_dat, input logic [3:0] exp_iack);
        stb_i = 1'b1;
        run_to_ce();
        chk({tag, "_ack"}, {15'b0, ack_o}, 16'd1);
        chk({tag, "_dat"}, dat_o, exp_dat);
        chk({tag, "_iack"}, {12'b0, iack}, {12'b0, exp_iack});
        chk({tag, "_irqlow"}, {15'b0, irq_o}, 16'd0);
        tick();
        chk({tag, "_iack_end"}, {12'b0, iack}, 16'd0);
        stb_i = 1'b0;
        run_to_ce();
        chk({tag, "_rel_ack"}, {15'b0, ack_o}, 16'd0);
        chk({tag, "_rel_dat"}, dat_o, 16'd0);
    endtask

    initial begin
        vecs[0] = 16'o000060; vecs[1] = 16'o000274;
        vecs[2] = 16'o001234; vecs[3] = 16'o007654;
        for (int k = 0; k < NCH; k++) ivec[16*k +: 16] = vecs[k];
        m_prev = '0;
        reset = 1; ce = 0; stb_i = 0; ireq = '0; imask = '0;
        repeat (3) tick();
        chk("rst_pend", {12'b0, pend}, 16'd0);
        chk("rst_irq", {15'b0, irq_o}, 16'd0);
        reset = 0;
        run_to_ce();

        // Single-cycle pulse on channel 1 between ce edges.
        ireq = 4'b0010; tick(); ireq = 4'b0000;
        chk("s1_pend", {12'b0, pend}, 16'b0010);
        run_to_ce();
        chk("s1_irq", {15'b0, irq_o}, 16'd1);
        do_ack("s1", 16'o000274, 4'b0010);
        chk("s1_pend_clr", {12'b0, pend}, 16'd0);
        chk("s1_irq_end", {15'b0, irq_o}, 16'd0);

        // Simultaneous rise: channel 0 first, then channel 1.
        ireq = 4'b0011; tick(); ireq = 4'b0000;
        run_to_ce();
        do_ack("s2a", 16'o000060, 4'b0001);
        run_to_ce();
        chk("s2_irq_re", {15'b0, irq_o}, 16'd1);
        do_ack("s2b", 16'o000274, 4'b0010);

        // Masked channel 0 is kept and presented after unmasking.
        ireq = 4'b0011; tick(); ireq = 4'b0000;
        imask = 4'b0001;
        run_to_ce();
        do_ack("s3a", 16'o000274, 4'b0010);
        imask = 4'b0000;
        run_to_ce();
        chk("s3_irq_unmask", {15'b0, irq_o}, 16'd1);
        do_ack("s3b", 16'o000060, 4'b0001);

        // Level channel 3 serviced while still asserted.
        ireq = 4'b1000; tick();
        run_to_ce();
        do_ack("s4", 16'o007654, 4'b1000);
        chk("s4_pend_hold", {12'b0, pend}, 16'b1000);
        run_to_ce();
        chk("s4_irq_re", {15'b0, irq_o}, 16'd1);
        ireq = 4'b0000; tick();
        chk("s4_pend_drop", {12'b0, pend}, 16'd0);
        run_to_ce();
        chk("s4_irq_drop", {15'b0, irq_o}, 16'd0);

        // Acknowledge with nothing eligible returns the spurious vector.
        do_ack("s5", SPUR, 4'b0000);

        // Reset in the middle of ACK, with ireq held high through reset.
        ireq = 4'b0011; tick();
        run_to_ce();
        stb_i = 1'b1;
        run_to_ce();
        chk("s6_in_ack", {15'b0, ack_o}, 16'd1);
        reset = 1; tick();
        chk("s6_rst_ack", {15'b0, ack_o}, 16'd0);
        chk("s6_rst_pend", {12'b0, pend}, 16'd0);
        chk("s6_rst_iack", {12'b0, iack}, 16'd0);
        tick(); tick();
        reset = 0; stb_i = 0;
        repeat (5) tick();
        chk("s6_no_fire", {12'b0, pend}, 16'd0);
        ireq = 4'b0000;
        tick();

        // Random traffic with random ce, including occasional resets.
        rand_ce = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            ce = 1'($urandom_range(0, 1));
            ireq = ireq ^ (4'($urandom) & 4'($urandom));
            if ($urandom_range(0, 15) == 0) imask = 4'($urandom);
            if ($urandom_range(0, 3) == 0) stb_i = ~stb_i;
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
